// File: rtl/aes_xts_data_in_reg.sv
// Input block register for the AES-XTS-256 datapath: one-block lookahead toward the cipher core,
// flags block m-1 ahead of a partial final block, and merges that partial block with the stolen CC tail.
module aes_xts_data_in_reg (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inWr,
  input  logic [127:0] inData,
  input  logic         inLast,
  input  logic [4:0]   inLastBlockSize,
  output logic         outReady,
  output logic         outValid,
  input  logic         inCoreReady,
  output logic [127:0] outData,
  output logic         outBlockBeforeLast,
  output logic         outLast,
  output logic [7:0]   outExtLastBlockSize,
  input  logic         inStealWr,
  input  logic [127:0] inStealData,
  output logic         outErr,
  output logic [2:0]   outState
);

  typedef enum logic [2:0] {
    S_EMPTY      = 3'd0,
    S_HELD       = 3'd1,
    S_FLUSH      = 3'd2,
    S_WAIT_STEAL = 3'd3,
    S_EMIT_PP    = 3'd4
  } state_t;

  state_t       state, state_nxt;
  logic [127:0] reg_hold, hold_nxt;
  logic [127:0] reg_last, last_nxt;
  logic [4:0]   reg_size, size_nxt;
  logic [7:0]   ext_nxt;
  logic         err_nxt;
  logic         ld, ld_bbl, ld_last;
  logic [127:0] ld_data;
  logic [127:0] merged;
  logic         can_load, accept, size_full;
  logic [4:0]   size_eff;

  // Handshakes: a host block moves on a rising edge with inWr && outReady; a core block moves on a
  // rising edge with outValid && inCoreReady. outData and its flags hold steady while outValid && !inCoreReady.
  assign can_load  = !outValid || inCoreReady;
  assign outReady  = can_load && (state == S_EMPTY || state == S_HELD);
  assign accept    = inWr && outReady;
  assign size_full = (inLastBlockSize == 5'd0) || (inLastBlockSize >= 5'd16);
  assign size_eff  = size_full ? 5'd16 : inLastBlockSize;
  assign outState  = state;

  // PP = partial plaintext bytes in the low lanes, stolen ciphertext tail in the rest.
  always_comb begin
    merged = inStealData;
    for (int k = 0; k < 16; k++) begin
      if (5'(k) < reg_size) merged[8*k +: 8] = reg_last[8*k +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = reg_hold;
    last_nxt  = reg_last;
    size_nxt  = reg_size;
    ld        = 1'b0;
    ld_data   = '0;
    ld_bbl    = 1'b0;
    ld_last   = 1'b0;
    ext_nxt   = outExtLastBlockSize;
    err_nxt   = 1'b0;

    // The stealing size stays visible until the merged block has left for the core.
    if (outValid && inCoreReady && outLast) ext_nxt = 8'd0;

    case (state)
      S_EMPTY: begin
        if (accept) begin
          if (!inLast) begin
            hold_nxt  = inData;
            state_nxt = S_HELD;
          end else if (size_full) begin
            ld      = 1'b1;
            ld_data = inData;
            ld_last = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_HELD: begin
        if (accept) begin
          ld      = 1'b1;
          ld_data = reg_hold;
          if (!inLast) begin
            hold_nxt = inData;
          end else if (size_full) begin
            last_nxt  = inData;
            state_nxt = S_FLUSH;
          end else begin
            ld_bbl    = 1'b1;
            last_nxt  = inData;
            size_nxt  = size_eff;
            ext_nxt   = {size_eff, 3'b000};
            state_nxt = S_WAIT_STEAL;
          end
        end
      end
      S_FLUSH: begin
        if (can_load) begin
          ld        = 1'b1;
          ld_data   = reg_last;
          ld_last   = 1'b1;
          state_nxt = S_EMPTY;
        end
      end
      S_WAIT_STEAL: begin
        if (inStealWr) begin
          last_nxt  = merged;
          state_nxt = S_EMIT_PP;
        end
      end
      S_EMIT_PP: begin
        if (can_load) begin
          ld        = 1'b1;
          ld_data   = reg_last;
          ld_last   = 1'b1;
          state_nxt = S_EMPTY;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase

    if (inStealWr && state != S_WAIT_STEAL) err_nxt = 1'b1;
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state               <= S_EMPTY;
      reg_hold            <= '0;
      reg_last            <= '0;
      reg_size            <= '0;
      outData             <= '0;
      outValid            <= 1'b0;
      outBlockBeforeLast  <= 1'b0;
      outLast             <= 1'b0;
      outExtLastBlockSize <= 8'd0;
      outErr              <= 1'b0;
    end else begin
      state               <= state_nxt;
      reg_hold            <= hold_nxt;
      reg_last            <= last_nxt;
      reg_size            <= size_nxt;
      outExtLastBlockSize <= ext_nxt;
      outErr              <= err_nxt;
      if (ld) begin
        outValid           <= 1'b1;
        outData            <= ld_data;
        outBlockBeforeLast <= ld_bbl;
        outLast            <= ld_last;
      end else if (outValid && inCoreReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule
